sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
Host-side controller that drives a single-port, active-low-strobed SRAM macro with a 1-cycle read latency. Converts a valid/ready request channel (read or masked write) into macro strobes CEN/WEN/BWEN/A/D. Captures the macro output Q into a 2-entry response FIFO with credit-based flow control. Sits between pipeline/cache logic and the SRAM macro instances.

Parameters:
BITS, 128, data width of macro word
DEPTH, 64, number of macro words
ADDR_W, 6, address width (log2 DEPTH)

Ports:
CLK  input  1  clock; all state updates on posedge
RST_N  input  1  synchronous active-low reset, sampled on posedge CLK
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  BITS  write data
req_wmask  input  BITS  active-high per-bit write enable
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer accepts read data
rsp_rdata  output  BITS  read data, in request order
CEN  output  1  macro chip enable, active-low
WEN  output  1  macro write enable, active-low
BWEN  output  BITS  macro bit write enable, active-low
A  output  ADDR_W  macro address
D  output  BITS  macro write data
Q  input  BITS  macro read data, valid only in the cycle after a read strobe

Behaviour:
- Reset is synchronous and active-low. While RST_N=0 at a posedge: FIFO is emptied, the in-flight flag is cleared, the FSM enters its reset state, and req_ready=0. Macro outputs are combinational from req; whenever not issuing they are CEN=1, WEN=1, BWEN all ones, A=0, D=0. rsp_valid=0.
- FSM states: INIT (only with the optional feature) and RUN. Without the feature, reset goes directly to RUN.
- Write acceptance (RUN): req_ready=1 whenever req_write=1. On fire, in the same cycle: CEN=0, WEN=0, BWEN=~req_wmask, A=req_addr, D=req_wdata. A write produces no response.
- Read credit: occ = FIFO count (0..2); infl = read issued in the previous cycle (0/1); pop = rsp_valid && rsp_ready. A read may be accepted iff occ + infl - pop < 2. When req_write=0, req_ready equals this condition.
- Read fire: CEN=0, WEN=1, BWEN all ones, A=req_addr. infl is set for the next cycle.
- Capture: in the cycle where infl=1, Q is pushed into the FIFO at that cycle's closing posedge. Q is never sampled in any other cycle, because its value is undefined when no read was issued.
- Latency: read fire at cycle T gives rsp_valid at T+2 with an empty FIFO. Sustained throughput is 1 read/cycle while rsp_ready=1.
- Simultaneous push and pop in one cycle leaves occ unchanged. Data order is preserved.
- rsp_valid = (occ != 0). rsp_rdata = FIFO head. rsp_rdata holds stable while rsp_valid && !rsp_ready.
- The credit rule guarantees no push into a full FIFO. This is checked by an assertion.
- Reset mid-operation discards any in-flight read and all buffered data.
- Interleaved writes and reads to the same address: a read issued after a write sees the new data, because the macro completes the write before the next access.

Optional Feature:
SRAM_INIT_EN. When defined, reset enters INIT:
- A counter sweeps addresses 0..DEPTH-1, one per cycle, with CEN=0, WEN=0, BWEN all zeros, D=0.
- req_ready=0 throughout INIT.
- After writing address DEPTH-1, the FSM moves to RUN. INIT lasts exactly DEPTH cycles after RST_N rises.
- Reset during INIT restarts the sweep from address 0.

When SRAM_INIT_EN is undefined: no INIT state or counter; req_ready may assert in the first cycle after reset; macro contents are undefined until written.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles -> CEN=1, WEN=1, BWEN all ones, req_ready=0, rsp_valid=0; the cycle after release, req_ready=1 (no SRAM_INIT_EN).
- Masked write then read: write addr 5, wdata all 0xA5, wmask low 64 bits only, over prior all-ones data; read addr 5 -> rsp_rdata = high 64 bits 1s, low 64 bits 0xA5A5...; rsp_valid asserts exactly 2 cycles after read fire.
- Back-to-back reads: addrs 0..7 each holding its address value, rsp_ready=1 -> 8 responses in order, one per cycle, req_ready continuously 1.
- Backpressure: issue 4 reads with rsp_ready=0 -> only 2 accepted (FIFO full), req_ready=0, rsp_rdata stable; raise rsp_ready -> remaining reads accepted, order preserved, no data lost.
- Reset mid-operation: reads in flight with FIFO holding 2 entries, assert RST_N=0 for 1 cycle -> rsp_valid=0 next cycle, stale data never appears.
- SRAM_INIT_EN: after reset, count cycles with req_ready=0 -> exactly 64; CEN=0 and WEN=0 with A stepping 0..63; subsequent read of addr 63 -> rsp_rdata=0.

Source files
------------

// File: rtl/sram_port_ctrl_if.sv
// Request/response channel between host logic and sram_port_ctrl.
// Both channels use one handshake rule: a transfer happens in the cycle where
// valid && ready are both high at the posedge; valid never waits on ready.
interface sram_port_ctrl_if #(
    parameter int BITS   = 128,
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [BITS-1:0]   req_wdata;
    logic [BITS-1:0]   req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [BITS-1:0]   rsp_rdata;

    // Host side: issues requests, consumes read responses.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_ctrl.sv
// Host-side controller for a single-port SRAM macro with active-low strobes
// and 1-cycle read latency. Requests are turned into CEN/WEN/BWEN/A/D in the
// same cycle they are accepted; read data is captured into a 2-entry FIFO and
// reads are only accepted when a FIFO slot is guaranteed for them.
// Optional build macro: SRAM_INIT_EN -- after reset, zero every macro word
// (one per cycle) before accepting requests.
module sram_port_ctrl #(
    parameter int BITS   = 128,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                CLK,
    input  logic                RST_N,
    sram_port_ctrl_if.slave     bus,
    output logic                CEN,
    output logic                WEN,
    output logic [BITS-1:0]     BWEN,
    output logic [ADDR_W-1:0]   A,
    output logic [BITS-1:0]     D,
    input  logic [BITS-1:0]     Q,
    output logic [0:0]          dbg_state
);

`ifdef SRAM_INIT_EN
    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    localparam state_t ST_RESET = ST_INIT;
`else
    typedef enum logic [0:0] {ST_RUN = 1'b1} state_t;
    localparam state_t ST_RESET = ST_RUN;
`endif

    state_t            state_q;
    state_t            state_d;

    // Response FIFO: two data slots, 1-bit pointers, occupancy 0..2.
    logic [BITS-1:0]   fifo_mem [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;
    logic              infl_q;     // a read strobe was issued last cycle

    logic              pop;
    logic [2:0]        credit_sum;
    logic              read_ok;
    logic              run;
    logic              ready;
    logic              fire;

`ifdef SRAM_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q;
`endif

    assign pop        = bus.rsp_valid && bus.rsp_ready;
    // Slots that will be occupied after this cycle if no new read fires.
    // pop implies occ_q >= 1, so this never underflows.
    assign credit_sum = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign read_ok    = (credit_sum < 3'd2);
    assign run        = (state_q == ST_RUN);
    // Gated by RST_N so nothing is accepted while reset is being applied.
    assign ready      = RST_N && run && (bus.req_write || read_ok);
    assign fire       = bus.req_valid && ready;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (occ_q != 2'd0);
    assign bus.rsp_rdata = fifo_mem[rd_ptr_q];
    assign dbg_state     = state_q;

    // State register; reset always restarts from the reset state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: INIT leaves after the last address has been written.
    always_comb begin
        state_d = state_q;
`ifdef SRAM_INIT_EN
        if (state_q == ST_INIT && init_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
        end
`endif
    end

`ifdef SRAM_INIT_EN
    // Init sweep address, one word per cycle while in INIT.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
        end
    end
`endif

    // Macro strobes: idle values unless the init sweep or a request is issuing.
    always_comb begin
        CEN  = 1'b1;
        WEN  = 1'b1;
        BWEN = '1;
        A    = '0;
        D    = '0;
`ifdef SRAM_INIT_EN
        if (RST_N && state_q == ST_INIT) begin
            CEN  = 1'b0;
            WEN  = 1'b0;
            BWEN = '0;
            A    = init_cnt_q;
        end else
`endif
        if (fire) begin
            CEN = 1'b0;
            A   = bus.req_addr;
            if (bus.req_write) begin
                WEN  = 1'b0;
                BWEN = ~bus.req_wmask;
                D    = bus.req_wdata;
            end
        end
    end

    // FIFO control and in-flight tracking; reset drops everything pending.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            infl_q   <= 1'b0;
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            infl_q <= fire && !bus.req_write;
            if (infl_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

    // Q is only meaningful the cycle after a read strobe, so capture only then.
    always_ff @(posedge CLK) begin
        if (RST_N && infl_q) begin
            fifo_mem[wr_ptr_q] <= Q;
        end
    end

    // The read credit rule must never let a capture land in a full FIFO.
    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
        !(infl_q && occ_q == 2'd2 && !pop));

    // Any issued strobe must address a word that exists.
    a_addr_range: assert property (@(posedge CLK) disable iff (!RST_N)
        !CEN |-> (int'(A) < DEPTH));

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl: a behavioural SRAM macro, a reference
// memory plus expected-response queue, and a linear sequence of steps.
module tb_sram_port_ctrl;
    localparam int BITS   = 128;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              CEN;
    logic              WEN;
    logic [BITS-1:0]   BWEN;
    logic [ADDR_W-1:0] A;
    logic [BITS-1:0]   D;
    logic [BITS-1:0]   Q;
    logic [0:0]        dbg_state;

    sram_port_ctrl_if #(.BITS(BITS), .ADDR_W(ADDR_W)) bus ();

    sram_port_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .CEN       (CEN),
        .WEN       (WEN),
        .BWEN      (BWEN),
        .A         (A),
        .D         (D),
        .Q         (Q),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 CLK = ~CLK;

    // Behavioural macro: masked write, 1-cycle read, garbage Q otherwise.
    logic [BITS-1:0] sram_mem [DEPTH];
    always @(posedge CLK) begin
        if (!CEN && !WEN) begin
            sram_mem[A] <= (sram_mem[A] & BWEN) | (D & ~BWEN);
        end
        if (!CEN && WEN) begin
            Q <= sram_mem[A];
        end else begin
            Q <= {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Scoreboard state.
    logic [BITS-1:0] ref_mem [DEPTH];
    logic [BITS-1:0] exp_q[$];
    int              total = 0;
    int              bad   = 0;
    logic            fired;

    task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle, record a request fire, check a response pop.
    task automatic cycle();
        #1;
        fired = bus.req_valid && bus.req_ready;
        if (fired) begin
            if (bus.req_write) begin
                ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask)
                                      | (bus.req_wdata & bus.req_wmask);
            end else begin
                exp_q.push_back(ref_mem[bus.req_addr]);
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            check("rsp_pending", BITS'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [BITS-1:0] data,
                            input logic [BITS-1:0] mask);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_wmask = mask;
        cycle();
        check("wr_fire", BITS'(fired), 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        fired = 1'b0;
        for (int n = 0; n < 20 && !fired; n++) begin
            cycle();
        end
        check("rd_fire", BITS'(fired), 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            cycle();
        end
        check("drain_empty", BITS'(exp_q.size()), 0);
    endtask

    // After reset release: wait out the init sweep (if built) or expect
    // immediate readiness.
    task automatic after_release();
`ifdef SRAM_INIT_EN
        int   n;
        logic sweep_ok;
        n = 0;
        sweep_ok = 1'b1;
        #1;
        while (!bus.req_ready && n < 200) begin
            if (CEN !== 1'b0 || WEN !== 1'b0 || BWEN !== '0 || A !== n[ADDR_W-1:0]) sweep_ok = 1'b0;
            n++;
            @(posedge CLK);
            #1;
        end
        check("init_cycles", BITS'(n), 64);
        check("init_sweep", BITS'(sweep_ok), 1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        #1;
        check("ready_after_rst", BITS'(bus.req_ready), 1);
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        RST_N         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cen", BITS'(CEN), 1);
        check("rst_wen", BITS'(WEN), 1);
        check("rst_bwen", BWEN, {BITS{1'b1}});
        check("rst_a", BITS'(A), 0);
        check("rst_d", D, 0);
        check("rst_ready", BITS'(bus.req_ready), 0);
        check("rst_rsp_valid", BITS'(bus.rsp_valid), 0);
        RST_N = 1'b1;
        after_release();

`ifdef SRAM_INIT_EN
        // Swept contents read back as zero.
        bus.rsp_ready = 1'b1;
        do_read(6'd63);
        drain();
`endif

        // Masked write over all-ones data, with strobe checks.
        do_write(6'd5, {BITS{1'b1}}, {BITS{1'b1}});
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 6'd5;
        bus.req_wdata = {16{8'hA5}};
        bus.req_wmask = {{64{1'b0}}, {64{1'b1}}};
        #1;
        check("mw_cen", BITS'(CEN), 0);
        check("mw_wen", BITS'(WEN), 0);
        check("mw_bwen", BWEN, {{64{1'b1}}, {64{1'b0}}});
        check("mw_a", BITS'(A), 5);
        check("mw_d", D, {16{8'hA5}});
        cycle();
        bus.req_valid = 1'b0;

        // Read addr 5: strobes, then exact 2-cycle latency.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        #1;
        check("rd_ready", BITS'(bus.req_ready), 1);
        check("rd_cen", BITS'(CEN), 0);
        check("rd_wen", BITS'(WEN), 1);
        check("rd_bwen", BWEN, {BITS{1'b1}});
        check("rd_a", BITS'(A), 5);
        cycle();
        bus.req_valid = 1'b0;
        #1;
        check("lat_t1_valid", BITS'(bus.rsp_valid), 0);
        @(posedge CLK);
        #2;
        check("lat_t2_valid", BITS'(bus.rsp_valid), 1);
        check("masked_data", bus.rsp_rdata, {{64{1'b1}}, {8{8'hA5}}});
        drain();

        // Preload addresses 0..7 with their own address.
        for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), BITS'(i), {BITS{1'b1}});

        // Back-to-back reads, one per cycle.
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = ADDR_W'(i);
            cycle();
            check($sformatf("b2b_fire_%0d", i), BITS'(fired), 1);
        end
        check("b2b_outstanding", BITS'(exp_q.size()), 2);
        drain();

        // Backpressure: only two reads fit while the consumer stalls.
        bus.rsp_ready = 1'b0;
        do_read(6'd4);
        do_read(6'd5);
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd6;
        #1;
        check("bp_ready_0", BITS'(bus.req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #2;
            check($sformatf("bp_ready_%0d", k + 1), BITS'(bus.req_ready), 0);
            check($sformatf("bp_hold_%0d", k), bus.rsp_rdata, 4);
        end
        bus.rsp_ready = 1'b1;
        do_read(6'd6);
        do_read(6'd7);
        drain();

        // Reset with a full FIFO: buffered data must be dropped.
        bus.rsp_ready = 1'b0;
        do_read(6'd6);
        do_read(6'd7);
        @(posedge CLK);
        #2;
        check("pre_rst_valid", BITS'(bus.rsp_valid), 1);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        exp_q.delete();
        #1;
        check("post_rst_valid", BITS'(bus.rsp_valid), 0);
        after_release();
        bus.rsp_ready = 1'b1;
        repeat (3) cycle();
`ifndef SRAM_INIT_EN
        do_write(6'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, {BITS{1'b1}});
`endif
        do_read(6'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
